// File: rtl/serial_operand_shifter_pkg.sv
// Shared definitions for the bit-serial adder datapath: the frame FSM encoding and the
// default operand geometry used by the feeder, the adder and the downstream collector.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_FLUSH = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bit counter width: holds 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_operand_shifter_piso_reg.sv
// Parallel-in serial-out register: load wins over shift, zeros shift in from the MSB,
// so the serial output reads 0 once every operand bit has been emitted.
module piso_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: the shift register is reset too, so a_ser/b_ser read 0 outside frames and after an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= {1'b0, data_q[WIDTH-1:1]};
        end
    end

    assign ser_o = data_q[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// Feeds two WIDTH-bit operands LSB-first to the bit-serial adder, framed by first/last,
// with an optional trailing zero bit so the adder can emit its carry-out.
module serial_operand_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FLUSH = DEFAULT_FLUSH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             a_ser,
    output logic             b_ser,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MAX_IDX  = CNT_W'(WIDTH);

    state_t           state_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_inc;
    logic             bit_valid_q;
    logic             first_q;
    logic             last_q;
    logic             busy_q;
    logic             accept;
    logic             shift;

    // A new pair may be taken in the final bit cycle, giving gap-free back-to-back frames.
    assign in_ready = (state_q == ST_IDLE) || last_q;
    assign accept   = in_valid && in_ready;
    assign shift    = (state_q == ST_SHIFT);
    assign idx_inc  = idx_q + CNT_W'(1);

    piso_reg #(.WIDTH(WIDTH)) u_piso_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (shift),
        .data_i  (op_a),
        .ser_o   (a_ser)
    );

    piso_reg #(.WIDTH(WIDTH)) u_piso_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (shift),
        .data_i  (op_b),
        .ser_o   (b_ser)
    );

    // NOTE: state and flags use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= ST_SHIFT;
            idx_q       <= '0;
            bit_valid_q <= 1'b1;
            first_q     <= 1'b1;
            last_q      <= (FLUSH == 0) && (LAST_IDX == '0);
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (idx_q >= MAX_IDX) begin
                        state_q     <= ST_IDLE;
                        idx_q       <= '0;
                        bit_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        state_q     <= (FLUSH != 0) ? ST_FLUSH : ST_IDLE;
                        idx_q       <= '0;
                        bit_valid_q <= (FLUSH != 0);
                        first_q     <= 1'b0;
                        last_q      <= (FLUSH != 0);
                        busy_q      <= (FLUSH != 0);
                    end else begin
                        idx_q       <= idx_inc;
                        bit_valid_q <= 1'b1;
                        first_q     <= 1'b0;
                        last_q      <= (FLUSH == 0) && (idx_inc == LAST_IDX);
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= '0;
                    bit_valid_q <= 1'b0;
                    first_q     <= 1'b0;
                    last_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bit_valid = bit_valid_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = busy_q;

endmodule
